ttl_ctr: RTL

Parametrised synchronous presettable counter for the discrete-TTL logic library: a generalised 74LS160/161/162/163 in one block. Width, modulus and clear style are parameters, so one module replaces the fixed 4-bit decade and binary parts in the video timing chains, score counters and ball-motion logic. Ripple-carry cascading follows the 74LS16x ENP/ENT/RCO convention, so multi-stage chains are built exactly as on the original schematic.

---
 rtl/ttl_ctr.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ttl_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : ttl_ctr
//  Purpose  : Parametrised synchronous presettable counter modelled on the
//             74LS160/161/162/163 family. Width, modulus and clear style are
//             parameters; cascading uses the ENP/ENT/RCO ripple-carry scheme.
//
//  Parameters
//    WIDTH    : counter width in bits (1..16)
//    MODULUS  : count length (2..2**WIDTH); 10 with WIDTH=4 gives a decade part
//    SYNC_CLR : 1 = clr_n synchronous (LS162/163), 0 = asynchronous (LS160/161)
//
//  Ports
//    clk     in   rising-edge system clock
//    rst_n   in   asynchronous active-low reset, forces q to 0
//    clr_n   in   active-low clear (sync or async per SYNC_CLR)
//    load_n  in   active-low synchronous parallel load of d
//    enp     in   count enable P
//    ent     in   count enable T, also gates rco
//    up      in   count direction, 1 = up (only with TTL_CTR_UPDOWN_EN)
//    d       in   parallel load data
//    q       out  registered counter value
//    rco     out  combinational ripple carry out (ent & terminal count)
//
//  Build option
//    TTL_CTR_UPDOWN_EN : when defined, adds the up port and the down-count
//                        path. When undefined the block counts up only.
//
//  Revision : 1.0  initial release
// ============================================================================
module ttl_ctr #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int SYNC_CLR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
`ifdef TTL_CTR_UPDOWN_EN
    input  logic             up,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    // Last in-range value; MODULUS-1 always fits in WIDTH bits.
    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_step_up;
    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH-1:0] w_q_next;
    logic             w_tc;

    // Up step: anything at or beyond the last in-range value goes to zero,
    // which is also how an out-of-range load recovers.
    always_comb begin
        w_step_up = r_q + C_ONE;
        if (r_q >= C_LAST) begin
            w_step_up = '0;
        end
    end

`ifdef TTL_CTR_UPDOWN_EN
    logic [WIDTH-1:0] w_step_down;

    // Down step: zero wraps to the last in-range value; out-of-range values
    // simply decrement toward the valid range.
    always_comb begin
        w_step_down = r_q - C_ONE;
        if (r_q == '0) begin
            w_step_down = C_LAST;
        end
    end

    always_comb begin
        w_q_step = w_step_up;
        w_tc     = (r_q == C_LAST);
        if (!up) begin
            w_q_step = w_step_down;
            w_tc     = (r_q == '0);
        end
    end
`else
    always_comb begin
        w_q_step = w_step_up;
        w_tc     = (r_q == C_LAST);
    end
`endif

    // Edge priority: clear, load, count, hold.
    always_comb begin
        w_q_next = r_q;
        if (!clr_n) begin
            w_q_next = '0;
        end else if (!load_n) begin
            w_q_next = d;
        end else if (enp && ent) begin
            w_q_next = w_q_step;
        end
    end

    generate
        if (SYNC_CLR != 0) begin : g_sync_clr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_q_next;
                end
            end
        end else begin : g_async_clr
            // clr_n joins the sensitivity list so it clears without a clock
            // and holds q at zero for as long as it stays low.
            always_ff @(posedge clk or negedge rst_n or negedge clr_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (!clr_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_q_next;
                end
            end
        end
    endgenerate

    assign q = r_q;

    // rco is deliberately not gated by enp so that a chain sharing enp sees
    // every upper stage's ent settle before the common edge.
    assign rco = ent & w_tc;

endmodule
`default_nettype wire
